arbitro_mux4_rr: RTL and testbench

//  Round-robin arbiter sharing one memory port among 4 requesters (PC fetch,

---
 rtl/arbitro_mux4_rr_if.sv | 30 +++
 rtl/arbitro_mux4_rr.sv | 139 +++++++++++++
 tb/tb_arbitro_mux4_rr.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/arbitro_mux4_rr_if.sv
// rtl/arbitro_mux4_rr_if.sv - requester/memory-mux bundle of the 4-way round-robin arbiter
interface arbitro_mux4_rr_if;
  logic [3:0] req;
  logic [3:0] wr_req;
  logic [1:0] controlador;
  logic [3:0] grant;
  logic       mem_wr;
  logic [3:0] ack;
  logic       busy;

  modport master (
    output req,
    output wr_req,
    input  controlador,
    input  grant,
    input  mem_wr,
    input  ack,
    input  busy
  );

  modport slave (
    input  req,
    input  wr_req,
    output controlador,
    output grant,
    output mem_wr,
    output ack,
    output busy
  );
endinterface

// File: rtl/arbitro_mux4_rr.sv
// rtl/arbitro_mux4_rr.sv - round-robin arbiter for the shared memory port, fixed-latency access timing
module arbitro_mux4_rr #(
  parameter int LATENCIA = 3,
  parameter int CW       = 2
) (
  input  logic             clk,
  input  logic             reset,
  arbitro_mux4_rr_if.slave bus
);

  localparam int CNTW = (LATENCIA > 1) ? $clog2(LATENCIA) : 1;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    ACESSO = 2'd1,
    LIBERA = 2'd2
  } estado_t;

  estado_t         estado, estado_nx;
  logic [CNTW-1:0] cnt, cnt_nx;
  logic [CW-1:0]   ptr, ptr_nx;
  logic [CW-1:0]   sel, sel_nx;
  logic [CW-1:0]   ctrl, ctrl_nx;
  logic [3:0]      grant, grant_nx;
  logic [3:0]      ack, ack_nx;
  logic            mem_wr, mem_wr_nx;
  logic            busy, busy_nx;

  logic [CW-1:0]   cand;
  logic [CW-1:0]   idx;
  logic [3:0]      onehot;
  logic            achou;

  // Scan starts one past the last-served requester, so rotation is strict.
  always_comb begin
    cand  = '0;
    idx   = '0;
    achou = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + CW'(k);
      if (!achou && bus.req[idx]) begin
        achou = 1'b1;
        cand  = idx;
      end
    end
    onehot = 4'b0001 << cand;
  end

  always_comb begin
    estado_nx = estado;
    cnt_nx    = cnt;
    ptr_nx    = ptr;
    sel_nx    = sel;
    ctrl_nx   = ctrl;
    grant_nx  = grant;
    ack_nx    = '0;
    mem_wr_nx = mem_wr;
    busy_nx   = busy;

    case (estado)
      OCIOSO: begin
        grant_nx  = '0;
        mem_wr_nx = 1'b0;
        busy_nx   = 1'b0;
        if (achou) begin
          sel_nx    = cand;
          ctrl_nx   = cand;
          grant_nx  = onehot;
          mem_wr_nx = bus.wr_req[cand];
          busy_nx   = 1'b1;
          cnt_nx    = CNTW'(LATENCIA - 1);
          ack_nx    = (LATENCIA == 1) ? onehot : 4'b0000;
          estado_nx = ACESSO;
        end
      end

      ACESSO: begin
        if (cnt == '0) begin
          grant_nx  = '0;
          mem_wr_nx = 1'b0;
          busy_nx   = 1'b0;
          ptr_nx    = sel;
          estado_nx = LIBERA;
        end else begin
          cnt_nx = cnt - CNTW'(1);
          // ack is registered, so it is raised on the edge into the final grant cycle
          if (cnt == CNTW'(1)) begin
            ack_nx = grant;
          end
        end
      end

      LIBERA: begin
        grant_nx  = '0;
        mem_wr_nx = 1'b0;
        busy_nx   = 1'b0;
        estado_nx = OCIOSO;
      end

      default: begin
        grant_nx  = '0;
        mem_wr_nx = 1'b0;
        busy_nx   = 1'b0;
        estado_nx = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= OCIOSO;
      cnt    <= '0;
      ptr    <= {CW{1'b1}};
      sel    <= '0;
      ctrl   <= '0;
      grant  <= '0;
      ack    <= '0;
      mem_wr <= 1'b0;
      busy   <= 1'b0;
    end else begin
      estado <= estado_nx;
      cnt    <= cnt_nx;
      ptr    <= ptr_nx;
      sel    <= sel_nx;
      ctrl   <= ctrl_nx;
      grant  <= grant_nx;
      ack    <= ack_nx;
      mem_wr <= mem_wr_nx;
      busy   <= busy_nx;
    end
  end

  assign bus.controlador = ctrl;
  assign bus.grant       = grant;
  assign bus.ack         = ack;
  assign bus.mem_wr      = mem_wr;
  assign bus.busy        = busy;

endmodule

// File: tb/tb_arbitro_mux4_rr.sv
// tb/tb_arbitro_mux4_rr.sv - scoreboard bench for arbitro_mux4_rr at LATENCIA 3 and 1
module tb_arbitro_mux4_rr;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arbitro_mux4_rr_if bus_a ();
  arbitro_mux4_rr_if bus_b ();

  arbitro_mux4_rr #(.LATENCIA(3)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  arbitro_mux4_rr #(.LATENCIA(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  typedef struct {
    int         dut;
    logic [3:0] grant;
    logic [3:0] ack;
    logic [1:0] ctrl;
    logic       mem_wr;
    logic       busy;
  } exp_t;

  exp_t fila[$];
  int   ordem[$];

  int         m_st   [2];
  int         m_left [2];
  int         m_own  [2];
  int         m_ptr  [2];
  logic [1:0] m_ctrl [2];
  logic       m_wr   [2];
  int         lat_of [2] = '{3, 1};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: observed %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference: m_left counts grant cycles still to be shown, including the current one.
  task automatic model_step(input int d, input logic rst, input logic [3:0] rq, input logic [3:0] wr);
    exp_t e;
    e.dut    = d;
    e.grant  = '0;
    e.ack    = '0;
    e.mem_wr = 1'b0;
    e.busy   = 1'b0;
    if (rst) begin
      m_st[d]   = 0;
      m_ptr[d]  = 3;
      m_ctrl[d] = 2'd0;
    end else begin
      case (m_st[d])
        0: begin
          for (int k = 1; k <= 4; k++) begin
            int i;
            i = (m_ptr[d] + k) % 4;
            if (m_st[d] == 0 && rq[i]) begin
              m_own[d]  = i;
              m_st[d]   = 1;
              m_left[d] = lat_of[d];
              m_ctrl[d] = 2'(i);
              m_wr[d]   = wr[i];
            end
          end
        end
        1: begin
          m_left[d]--;
          if (m_left[d] == 0) begin
            m_st[d]  = 2;
            m_ptr[d] = m_own[d];
          end
        end
        default: m_st[d] = 0;
      endcase
    end
    if (m_st[d] == 1) begin
      e.grant  = 4'b0001 << m_own[d];
      e.busy   = 1'b1;
      e.mem_wr = m_wr[d];
      if (m_left[d] == 1) e.ack = e.grant;
    end
    e.ctrl = m_ctrl[d];
    fila.push_back(e);
  endtask

  task automatic cycle(input logic rst, input logic [3:0] rq, input logic [3:0] wr);
    exp_t       e;
    logic [3:0] g_prev;
    logic [3:0] g, a;
    logic [1:0] c;
    logic       w, b;
    reset        = rst;
    bus_a.req    = rq;
    bus_a.wr_req = wr;
    bus_b.req    = rq;
    bus_b.wr_req = wr;
    model_step(0, rst, rq, wr);
    model_step(1, rst, rq, wr);
    g_prev = bus_a.grant;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      e = fila.pop_front();
      if (e.dut == 0) begin
        g = bus_a.grant; a = bus_a.ack; c = bus_a.controlador; w = bus_a.mem_wr; b = bus_a.busy;
      end else begin
        g = bus_b.grant; a = bus_b.ack; c = bus_b.controlador; w = bus_b.mem_wr; b = bus_b.busy;
      end
      chk($sformatf("grant%0d", e.dut),  32'(g), 32'(e.grant));
      chk($sformatf("ack%0d", e.dut),    32'(a), 32'(e.ack));
      chk($sformatf("ctrl%0d", e.dut),   32'(c), 32'(e.ctrl));
      chk($sformatf("mem_wr%0d", e.dut), 32'(w), 32'(e.mem_wr));
      chk($sformatf("busy%0d", e.dut),   32'(b), 32'(e.busy));
    end
    if (g_prev == 4'b0000 && bus_a.grant != 4'b0000 && ordem.size() > 0) begin
      chk("order", 32'(bus_a.controlador), 32'(ordem.pop_front()));
    end
  endtask

  task automatic repeat_cycle(input int n, input logic rst, input logic [3:0] rq, input logic [3:0] wr);
    for (int i = 0; i < n; i++) cycle(rst, rq, wr);
  endtask

  initial begin
    reset        = 1'b1;
    bus_a.req    = '0;
    bus_a.wr_req = '0;
    bus_b.req    = '0;
    bus_b.wr_req = '0;

    repeat_cycle(2, 1'b1, 4'b0000, 4'b0000);

    // single requester from reset
    ordem.push_back(0);
    repeat_cycle(4, 1'b0, 4'b0001, 4'b0000);
    repeat_cycle(3, 1'b0, 4'b0000, 4'b0000);

    // all four held: full rotation and wrap back to req0
    cycle(1'b1, 4'b0000, 4'b0000);
    ordem = '{0, 1, 2, 3, 0};
    repeat_cycle(23, 1'b0, 4'b1111, 4'b1010);
    repeat_cycle(4, 1'b0, 4'b0000, 4'b0000);

    // alternating pair
    cycle(1'b1, 4'b0000, 4'b0000);
    ordem = '{0, 2, 0, 2};
    repeat_cycle(18, 1'b0, 4'b0101, 4'b0100);
    repeat_cycle(4, 1'b0, 4'b0000, 4'b0000);

    // write captured at grant, req/wr_req dropped mid-access
    ordem.push_back(1);
    repeat_cycle(2, 1'b0, 4'b0010, 4'b0010);
    repeat_cycle(5, 1'b0, 4'b0000, 4'b0000);

    // reset aborts an access; req0 wins afterwards
    cycle(1'b1, 4'b0000, 4'b0000);
    ordem = '{1, 0};
    repeat_cycle(2, 1'b0, 4'b0010, 4'b0000);
    cycle(1'b1, 4'b0011, 4'b0000);
    repeat_cycle(2, 1'b0, 4'b0011, 4'b0001);
    repeat_cycle(6, 1'b0, 4'b0000, 4'b0000);

    // single-cycle request for req3 (grant+ack together on the LATENCIA=1 instance)
    ordem.push_back(3);
    cycle(1'b0, 4'b1000, 4'b1000);
    repeat_cycle(5, 1'b0, 4'b0000, 4'b0000);

    chk("order_left", 32'(ordem.size()), 32'd0);

    for (int i = 0; i < 60; i++) begin
      logic [3:0] r, w;
      logic       rs;
      r  = 4'($urandom);
      w  = 4'($urandom);
      rs = ($urandom_range(0, 19) == 0);
      cycle(rs, r, w);
    end

    chk("fila_left", 32'(fila.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
